posit_accumulator: RTL and testbench
====================================

POSIT_ACCUMULATOR -- requirements
Module: posit_accumulator

Interface
REQ-001 Parameter NBITS, default 32: posit width in bits, es = 2.
REQ-002 Parameter CNT_W, default 16: width of the element counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element this cycle.
- in_data  in  NBITS  posit element to accumulate.
- in_last  in  1  element is the last of its packet.
- add_in1  out  NBITS  adder operand 1 (running sum).
- add_in2  out  NBITS  adder operand 2 (element).
- add_start  out  1  one-cycle adder issue strobe.
- add_result  in  NBITS  adder sum.
- add_inf  in  1  adder result is NaR.
- add_done  in  1  adder result valid, one-cycle strobe.
- out_valid  out  1  packet sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  NBITS  accumulated posit.
- out_inf  out  1  sum is NaR.
- out_count  out  CNT_W  number of elements in the packet.

Function
REQ-004 The FSM SHALL have four states, IDLE, ISSUE, WAIT and OUT, and SHALL leave reset in IDLE.
REQ-005 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-006 On handshake (in_valid & in_ready), the block SHALL register in_data as operand and in_last as a last flag, increment count (saturating at 2^CNT_W-1), and go to ISSUE.
REQ-007 In ISSUE, add_start SHALL be 1 for exactly one cycle, add_in1 SHALL equal acc and add_in2 SHALL equal the captured operand; next state SHALL be WAIT.
REQ-008 add_in1 and add_in2 SHALL hold their values from ISSUE until add_done.
REQ-009 In WAIT, on add_done the block SHALL set acc <= add_result and inf_flag <= inf_flag | add_inf, then go to OUT if the last flag is set, else to IDLE. The block SHALL tolerate any adder latency of 1 cycle or more (nominally 4).
REQ-010 add_done outside WAIT SHALL be ignored.
REQ-011 In OUT, out_valid SHALL be 1; out_sum SHALL be 0x80000000 if inf_flag is set, else acc; out_count SHALL equal count.
REQ-012 On out_valid & out_ready, the block SHALL clear acc to 0, inf_flag to 0 and count to 0, and go to IDLE; the next packet SHALL start from sum zero.
REQ-013 out_sum, out_inf and out_count SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 Peak throughput SHALL be one element per (adder latency + 2) cycles; only one addition SHALL be in flight at any time.
REQ-015 A single-element packet SHALL yield the adder's result for 0 + x.

Reset
REQ-016 Reset SHALL act asynchronously, including mid-packet: state IDLE, acc = 0, count = 0, inf_flag = 0, last flag = 0, and all outputs 0 except in_ready = 1 once reset deasserts.
REQ-017 An add_done arriving after reset from a pre-reset issue SHALL be discarded, per REQ-010.

Configuration
REQ-018 Macro POSIT_ACC_NAR_SKIP_EN:
- Defined: once inf_flag is set, remaining elements of the packet SHALL be accepted and counted but no add_start issued, so the state goes IDLE to OUT (on in_last) or IDLE to IDLE.
- Undefined: every element SHALL be issued to the adder regardless of inf_flag.

Verification
REQ-019 Packet {0x40000000 last} -> one add_start with add_in1=0, add_in2=0x40000000; out_sum=0x40000000, out_count=1.
REQ-020 Packet {0x40000000, 0x40000000, 0x40000000 last}, 4-cycle adder -> out_sum=0x4C000000, out_count=3; in_ready gaps of 6 cycles between elements.
REQ-021 Packet {0x40000000, 0x80000000, 0x40000000 last} -> out_inf=1, out_sum=0x80000000, out_count=3; with POSIT_ACC_NAR_SKIP_EN exactly 2 add_start pulses, without it 3.
REQ-022 out_ready held 0 for 10 cycles in OUT -> out_valid, out_sum and out_count stable and in_ready=0; next packet {0x40000000 last} -> 0x40000000.
REQ-023 Reset asserted in WAIT, then a stale add_done 2 cycles after release -> acc stays 0 and the next packet {0x48000000 last} -> 0x48000000, out_count=1.

Source files
------------

// File: rtl/posit_accumulator.sv
// posit_accumulator: sums the posit elements of each packet through an
// external posit adder, one addition in flight at a time.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_data/in_last : element input stream
//   add_in1/add_in2/add_start         : adder issue (running sum, element)
//   add_result/add_inf/add_done       : adder response
//   out_valid/out_ready/out_sum/out_inf/out_count : packet result stream
// Option: define POSIT_ACC_NAR_SKIP_EN to stop issuing additions once the
// running sum has become NaR; remaining elements are still counted.
module posit_accumulator #(
  parameter int NBITS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_last,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  output logic             add_start,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_inf,
  input  logic             add_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_sum,
  output logic             out_inf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [NBITS-1:0] acc_q;
  logic [NBITS-1:0] opnd_q;
  logic [CNT_W-1:0] count_q;
  logic             inf_q;
  logic             last_q;

  logic hs_in;
  logic hs_out;
  logic done_ok;
  logic skip;
  logic busy;

  assign hs_in   = in_valid & in_ready;
  assign hs_out  = out_valid & out_ready;
  // A done pulse only counts while we are waiting for it; anything else
  // (e.g. a response to an issue cut short by reset) is stale.
  assign done_ok = (state_q == WAIT) & add_done;
  assign busy    = (state_q == ISSUE) | (state_q == WAIT);

`ifdef POSIT_ACC_NAR_SKIP_EN
  // NaR is absorbing: once the sum is NaR, further additions are pointless.
  assign skip = inf_q;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (skip) begin
            state_d = in_last ? OUT : IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (add_done) begin
          state_d = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      inf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs_in) begin
        opnd_q  <= in_data;
        last_q  <= in_last;
        count_q <= (&count_q) ? count_q : count_q + ONE;
      end
      if (done_ok) begin
        acc_q <= add_result;
        inf_q <= inf_q | add_inf;
      end
      if (hs_out) begin
        acc_q   <= '0;
        inf_q   <= 1'b0;
        count_q <= '0;
        last_q  <= 1'b0;
      end
    end
  end

  // Operands are driven from ISSUE through WAIT; acc and opnd cannot
  // change in that window, so they hold until the done pulse.
  always_comb begin
    in_ready  = (state_q == IDLE);
    add_start = (state_q == ISSUE);
    add_in1   = busy ? acc_q : '0;
    add_in2   = busy ? opnd_q : '0;
    out_valid = (state_q == OUT);
    out_sum   = '0;
    out_inf   = 1'b0;
    out_count = '0;
    if (state_q == OUT) begin
      out_sum   = inf_q ? NAR : acc_q;
      out_inf   = inf_q;
      out_count = count_q;
    end
  end

endmodule

// File: tb/tb_posit_accumulator.sv
// tb_posit_accumulator: directed checks of posit_accumulator with a
// hand-driven adder whose sums are hand-computed posit constants.
module tb_posit_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic        add_start;
  logic [31:0] add_result;
  logic        add_inf;
  logic        add_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_inf;
  logic [15:0] out_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int s0, h1, h2, h3;

  posit_accumulator #(.NBITS(32), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .add_in1(add_in1),
    .add_in2(add_in2),
    .add_start(add_start),
    .add_result(add_result),
    .add_inf(add_inf),
    .add_done(add_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_inf(out_inf),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (add_start) starts <= starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Offer one element at a negedge; if it is issued, play the adder with
  // latency lat and response res/inf. Returns the handshake cycle.
  task automatic elem(input string tag, input logic [31:0] d,
                      input bit last, input bit issue,
                      input logic [31:0] a1, input int lat,
                      input logic [31:0] res, input bit inf,
                      output int hs);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    hs = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk({tag, ".start"}, 32'(add_start), 32'(issue));
    if (issue) begin
      chk({tag, ".a1"}, add_in1, a1);
      chk({tag, ".a2"}, add_in2, d);
      repeat (lat) @(negedge clk);
      chk({tag, ".a1hold"}, add_in1, a1);
      chk({tag, ".a2hold"}, add_in2, d);
      chk({tag, ".start0"}, 32'(add_start), 32'd0);
      add_done   = 1'b1;
      add_result = res;
      add_inf    = inf;
      @(negedge clk);
      add_done   = 1'b0;
      add_inf    = 1'b0;
      add_result = '0;
    end
  endtask

  task automatic outchk(input string tag, input logic [31:0] sum,
                        input bit inf, input logic [31:0] cnt);
    chk({tag, ".ov"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, out_sum, sum);
    chk({tag, ".inf"}, 32'(out_inf), 32'(inf));
    chk({tag, ".cnt"}, 32'(out_count), cnt);
    chk({tag, ".irdy0"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov0"}, 32'(out_valid), 32'd0);
    chk({tag, ".irdy1"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    add_result = '0;
    add_inf    = 1'b0;
    add_done   = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.irdy", 32'(in_ready), 32'd1);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.start", 32'(add_start), 32'd0);
    chk("rst.a1", add_in1, 32'd0);
    chk("rst.sum", out_sum, 32'd0);
    chk("rst.cnt", 32'(out_count), 32'd0);

    // single element: 0 + 1.0
    s0 = starts;
    elem("p1", 32'h40000000, 1, 1, 32'h0, 4, 32'h40000000, 0, h1);
    outchk("p1", 32'h40000000, 0, 32'd1);
    chk("p1.nstart", 32'(starts - s0), 32'd1);

    // 1+1+1 = 3.0, elements 6 cycles apart with a 4-cycle adder
    elem("p2a", 32'h40000000, 0, 1, 32'h0, 4, 32'h40000000, 0, h1);
    elem("p2b", 32'h40000000, 0, 1, 32'h40000000, 4, 32'h48000000, 0, h2);
    chk("p2.gap1", 32'(h2 - h1), 32'd6);
    elem("p2c", 32'h40000000, 1, 1, 32'h48000000, 4, 32'h4C000000, 0, h3);
    chk("p2.gap2", 32'(h3 - h2), 32'd6);
    outchk("p2", 32'h4C000000, 0, 32'd3);

    // NaR in the middle of a packet
    s0 = starts;
    elem("p3a", 32'h40000000, 0, 1, 32'h0, 2, 32'h40000000, 0, h1);
    elem("p3b", 32'h80000000, 0, 1, 32'h40000000, 2, 32'h80000000, 1, h1);
`ifdef POSIT_ACC_NAR_SKIP_EN
    elem("p3c", 32'h40000000, 1, 0, 32'h0, 2, 32'h0, 0, h1);
    chk("p3.nstart", 32'(starts - s0), 32'd2);
`else
    elem("p3c", 32'h40000000, 1, 1, 32'h80000000, 2, 32'h80000000, 1, h1);
    chk("p3.nstart", 32'(starts - s0), 32'd3);
`endif
    outchk("p3", 32'h80000000, 1, 32'd3);

    // backpressure on the result, then a clean restart from zero
    elem("p4a", 32'h40000000, 0, 1, 32'h0, 3, 32'h40000000, 0, h1);
    elem("p4b", 32'h40000000, 1, 1, 32'h40000000, 1, 32'h48000000, 0, h1);
    for (int i = 0; i < 10; i++) begin
      chk("hold.ov", 32'(out_valid), 32'd1);
      chk("hold.sum", out_sum, 32'h48000000);
      chk("hold.cnt", 32'(out_count), 32'd2);
      chk("hold.irdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    outchk("p4", 32'h48000000, 0, 32'd2);
    elem("p5", 32'h40000000, 1, 1, 32'h0, 4, 32'h40000000, 0, h1);
    outchk("p5", 32'h40000000, 0, 32'd1);

    // reset while waiting on the adder, then a stale done
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst.irdy", 32'(in_ready), 32'd1);
    chk("arst.a1", add_in1, 32'd0);
    chk("arst.a2", add_in2, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    add_done   = 1'b1;
    add_result = 32'hDEADBEEF;
    add_inf    = 1'b1;
    @(negedge clk);
    add_done   = 1'b0;
    add_inf    = 1'b0;
    add_result = '0;
    chk("stale.irdy", 32'(in_ready), 32'd1);
    chk("stale.ov", 32'(out_valid), 32'd0);
    elem("p6", 32'h48000000, 1, 1, 32'h0, 4, 32'h48000000, 0, h1);
    outchk("p6", 32'h48000000, 0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
